packing_shift_reg: RTL and testbench
====================================

# packing_shift_reg

Receive-side counterpart of the mapper's filling shift register. It accepts 0..MAPPER_PARALLELISM-1 valid bits per cycle, LSB-first, from the demapper and appends them to an internal bit buffer. It emits fixed MAPPER_PARALLELISM-bit words into the output data FIFO. An explicit flush drains the residue as one zero-padded word.

## Interface
- MAPPER_PARALLELISM, 8, word width and per-cycle bit-count bound; power of two, ≥ 4.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately when low.
- in_valid  in  1  d/c are offered this cycle.
- d  in  MAPPER_PARALLELISM  input bits; only d[c-1:0] meaningful, d[0] is the oldest bit.
- c  in  $clog2(MAPPER_PARALLELISM)  number of valid bits, 0..MAPPER_PARALLELISM-1.
- in_ready  out  1  input transfer occurs when in_valid && in_ready.
- flush  in  1  request to drain the residue; single-cycle pulse.
- out_fifo_full  in  1  output FIFO full; blocks word emission.
- q  out  MAPPER_PARALLELISM  current output word, buffer bits [P-1:0].
- data_out_fifo_wr_req  out  1  write strobe for q.
- flush_done  out  1  one-cycle pulse when the flush completes.
- occupancy  out  $clog2(MAPPER_PARALLELISM)+1  buffered bit count, 0..2P-2.

## Operation
- Buffer: 2P-1 bits, where P = MAPPER_PARALLELISM, plus count `cnt`. Invariant: all buffer bits at positions ≥ cnt are 0.
- States: RUN, FLUSH.
- emit (RUN) = (cnt ≥ P) && !out_fifo_full.
- in_ready = (state == RUN) && (cnt < P || emit).
- accept = in_valid && in_ready.
- Per cycle, emit and accept apply in the same cycle:
  - On emit, drop the low P bits and shift the buffer down by P.
  - On accept, write d[c-1:0] at positions cnt' .. cnt'+c-1, where cnt' is the post-shift count. Clear bits of d above c-1 before insertion.
  - cnt_next = cnt − (emit ? P : 0) + (accept ? c : 0). This is never more than 2P-2. Compute in $clog2(P)+1 bits with no overflow.
- c = 0 with in_valid is a legal accept and a no-op.
- FLUSH entry: a flush pulse in RUN enters FLUSH next cycle. Any same-cycle accept is included.
- flush in FLUSH is ignored.
- In FLUSH, in_ready = 0:
  - While cnt ≥ P: emit full words under out_fifo_full backpressure.
  - When 0 < cnt < P and !out_fifo_full: assert wr_req with q = buffer low P bits, zero-padded. Set cnt ← 0, pulse flush_done, and return to RUN.
  - When cnt = 0: pulse flush_done with no write, and return to RUN.
- data_out_fifo_wr_req = emit in RUN, or the FLUSH write condition above.
- q is always driven directly from buffer[P-1:0].

## Timing
- Reset values: buffer 0, cnt 0, state RUN.
- Resulting outputs in reset: q = 0, wr_req = 0, flush_done = 0, occupancy = 0, in_ready = 1.
- wr_req, in_ready and q are combinational from registered state plus out_fifo_full/in_valid. There is no extra output register.
- Latency: if an accept at edge k makes cnt ≥ P, wr_req is high in cycle k+1 when out_fifo_full = 0.
- Sustained throughput is one accept per cycle with no input bubbles while the FIFO is not full.
- Full FIFO with cnt ≥ P: in_ready = 0, buffer held, no bit loss.
- reset low mid-operation, including in FLUSH: immediate clear. The residue is discarded and no flush_done is issued.

## Structure
- Shared mapper package holds:
  - the MAPPER_PARALLELISM default;
  - CNT_W = $clog2(P)+1;
  - the RUN/FLUSH state enum.
- Bit insertion at the variable offset uses the codebase's generic `mux` per buffer bit, with select = bit index − cnt'. Out-of-range selects yield 0.
- There is no other sub-module.

## Test plan
P = 8 for all cases.
- Reset: assert reset low with no clock -> q = 0x00, wr_req = 0, occupancy = 0, in_ready = 1.
- Three accepts, c = 3, d = 3'b101 -> wr_req in the cycle after the third accept with q = 0x6D, then occupancy = 1.
- Backpressure: reach cnt = 12 with out_fifo_full = 1 -> in_ready = 0, wr_req = 0, occupancy stays 12. Release full -> one write, occupancy 4, in_ready = 1.
- Flush: cnt = 5, buffer bits 5'b10110 -> enters FLUSH, then one write with q = 0x16, flush_done pulse, occupancy 0. A second flush with cnt = 0 -> flush_done only, no write.
- Streaming: 8 consecutive accepts with c = 7, d = 7'h7F, out_fifo_full = 0 -> exactly 7 writes of 0xFF, final occupancy 0, in_ready never low.
- Mid-run async reset: cnt = 10 in FLUSH, reset pulsed low between edges -> all outputs clear immediately, state RUN, no flush_done.

Source files
------------

// File: rtl/packing_shift_reg_pkg.sv
// Shared definitions for the receive-side packing shift register:
// default parallelism, counter width helper and the RUN/FLUSH state encoding.
package packing_shift_reg_pkg;

    localparam int MAPPER_PARALLELISM_DEF = 8;
    localparam int CNT_W = $clog2(MAPPER_PARALLELISM_DEF) + 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Counter width able to hold 0..2P-2 for a given parallelism.
    function automatic int cnt_w(input int p);
        return $clog2(p) + 1;
    endfunction

endpackage

// File: rtl/packing_shift_reg_mux.sv
// Generic N:1 single-bit mux; selects outside 0..N-1 (including wrapped
// negative offsets) yield 0.
module packing_shift_reg_mux #(
    parameter int N  = 8,
    parameter int SW = 5
) (
    input  logic [N-1:0]  data_i,
    input  logic [SW-1:0] sel_i,
    output logic          y_o
);

    // Compare-and-select so an out-of-range select falls through to 0.
    always_comb begin
        y_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (sel_i == SW'(k)) begin
                y_o = data_i[k];
            end else begin
                y_o = y_o;
            end
        end
    end

endmodule

// File: rtl/packing_shift_reg.sv
// Packs 0..P-1 valid bits per cycle (LSB-first) into P-bit words for the
// output FIFO; a flush drains any residue as one zero-padded word.
module packing_shift_reg
    import packing_shift_reg_pkg::*;
#(
    parameter int MAPPER_PARALLELISM = MAPPER_PARALLELISM_DEF
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    input  logic [MAPPER_PARALLELISM-1:0]       d,
    input  logic [$clog2(MAPPER_PARALLELISM)-1:0] c,
    output logic                                in_ready,
    input  logic                                flush,
    input  logic                                out_fifo_full,
    output logic [MAPPER_PARALLELISM-1:0]       q,
    output logic                                data_out_fifo_wr_req,
    output logic                                flush_done,
    output logic [$clog2(MAPPER_PARALLELISM):0] occupancy
);

    localparam int P  = MAPPER_PARALLELISM;
    localparam int BW = 2 * P - 1;
    localparam int CW = cnt_w(P);
    localparam int SW = CW + 1;

    state_e        state_q, state_d;
    logic [BW-1:0] buf_q, buf_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          full_word_s;
    logic          emit_s;
    logic          accept_s;
    logic          flush_wr_s;
    logic [BW-1:0] buf_sh_s;
    logic [CW-1:0] cnt_sh_s;
    logic [P-1:0]  d_mask_s;
    logic [BW-1:0] ins_s;
    logic [SW-1:0] sel_s [BW];

    // Handshake, word drop and per-bit insertion offsets for this cycle.
    always_comb begin
        full_word_s = (cnt_q >= CW'(P));
        emit_s      = full_word_s && !out_fifo_full;
        in_ready    = (state_q == ST_RUN) && (!full_word_s || emit_s);
        accept_s    = in_valid && in_ready;
        if (emit_s) begin
            buf_sh_s = buf_q >> P;
            cnt_sh_s = cnt_q - CW'(P);
        end else begin
            buf_sh_s = buf_q;
            cnt_sh_s = cnt_q;
        end
        for (int k = 0; k < P; k++) begin
            d_mask_s[k] = d[k] & (k < int'(c));
        end
        // Negative offsets wrap to large values, which the mux maps to 0.
        for (int i = 0; i < BW; i++) begin
            sel_s[i] = SW'(i) - SW'(cnt_sh_s);
        end
    end

    for (genvar gi = 0; gi < BW; gi++) begin : g_ins
        packing_shift_reg_mux #(
            .N  (P),
            .SW (SW)
        ) u_mux (
            .data_i (d_mask_s),
            .sel_i  (sel_s[gi]),
            .y_o    (ins_s[gi])
        );
    end

    // Next-state: append accepted bits, handle flush drain and completion.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_sh_s | (accept_s ? ins_s : {BW{1'b0}});
        cnt_d      = cnt_sh_s + (accept_s ? CW'(c) : {CW{1'b0}});
        flush_wr_s = 1'b0;
        flush_done = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (full_word_s) begin
                    state_d = ST_FLUSH;
                end else if (cnt_q == {CW{1'b0}}) begin
                    flush_done = 1'b1;
                    state_d    = ST_RUN;
                end else if (!out_fifo_full) begin
                    flush_wr_s = 1'b1;
                    flush_done = 1'b1;
                    buf_d      = {BW{1'b0}};
                    cnt_d      = {CW{1'b0}};
                    state_d    = ST_RUN;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        data_out_fifo_wr_req = emit_s || flush_wr_s;
        q                    = buf_q[P-1:0];
        occupancy            = cnt_q;
    end

    // State, buffer and count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            buf_q   <= {BW{1'b0}};
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_packing_shift_reg.sv
// Self-checking bench for packing_shift_reg (P = 8): per-cycle vector table
// for handshake/count/strobes, bit-level scoreboard for the emitted words.
module tb_packing_shift_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] d;
    logic [2:0] c;
    logic       in_ready;
    logic       flush;
    logic       out_fifo_full;
    logic [7:0] q;
    logic       wr_req;
    logic       flush_done;
    logic [3:0] occupancy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       v;
        logic [2:0] c;
        logic [7:0] d;
        logic       full;
        logic       fl;
        logic       e_rdy;
        logic       e_wr;
        logic       e_fd;
        logic [3:0] e_occ;
    } vec_t;

    vec_t       vt[$];
    bit         mbits[$];
    logic [7:0] exp_q[$];

    packing_shift_reg #(.MAPPER_PARALLELISM(8)) dut (
        .clk                  (clk),
        .reset                (reset),
        .in_valid             (in_valid),
        .d                    (d),
        .c                    (c),
        .in_ready             (in_ready),
        .flush                (flush),
        .out_fifo_full        (out_fifo_full),
        .q                    (q),
        .data_out_fifo_wr_req (wr_req),
        .flush_done           (flush_done),
        .occupancy            (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic v, input logic [2:0] cc, input logic [7:0] dd,
                                input logic full, input logic fl, input logic rdy,
                                input logic wr, input logic fd, input logic [3:0] occ);
        vec_t t;
        t.v = v; t.c = cc; t.d = dd; t.full = full; t.fl = fl;
        t.e_rdy = rdy; t.e_wr = wr; t.e_fd = fd; t.e_occ = occ;
        vt.push_back(t);
    endfunction

    // Drive one cycle at the falling edge, check outputs, update scoreboard.
    task automatic step(input vec_t t);
        logic [7:0] w;
        @(negedge clk);
        in_valid = t.v; c = t.c; d = t.d; out_fifo_full = t.full; flush = t.fl;
        #1;
        check("in_ready", in_ready, t.e_rdy);
        check("wr_req", wr_req, t.e_wr);
        check("flush_done", flush_done, t.e_fd);
        check("occupancy", occupancy, t.e_occ);
        if (wr_req) begin
            if (exp_q.size() == 0) check("unexpected_write", 1, 0);
            else check("q_word", q, exp_q.pop_front());
        end
        if (t.v && t.e_rdy) begin
            for (int k = 0; k < int'(t.c); k++) mbits.push_back(t.d[k]);
        end
        while (mbits.size() >= 8) begin
            for (int k = 0; k < 8; k++) w[k] = mbits.pop_front();
            exp_q.push_back(w);
        end
        if (t.fl && mbits.size() > 0) begin
            w = 8'h00;
            for (int k = 0; mbits.size() > 0; k++) w[k] = mbits.pop_front();
            exp_q.push_back(w);
        end
    endtask

    initial begin
        vec_t t;
        reset = 1'b0; in_valid = 1'b0; d = 8'h00; c = 3'd0;
        flush = 1'b0; out_fifo_full = 1'b0;
        #2;
        check("rst_q", q, 8'h00);
        check("rst_wr", wr_req, 1'b0);
        check("rst_occ", occupancy, 4'd0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_fd", flush_done, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // three accepts of 3'b101 -> word 0x6D
        add(1'b1, 3'd3, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        add(1'b1, 3'd3, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
        add(1'b1, 3'd3, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6);
        add(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9);
        add(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        // backpressure at cnt = 12
        add(1'b1, 3'd4, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        add(1'b1, 3'd7, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5);
        add(1'b1, 3'd3, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd12);
        add(1'b1, 3'd3, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd12);
        add(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd12);
        add(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
        add(1'b1, 3'd0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
        // flushes: residue 4, residue 5 (masked d), empty, same-cycle accept + full
        add(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4);
        add(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4);
        add(1'b1, 3'd5, 8'hF6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        add(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5);
        add(1'b1, 3'd3, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5);
        add(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        add(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        add(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        add(1'b1, 3'd6, 8'h2A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        add(1'b1, 3'd1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6);
        add(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd6);
        add(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        // streaming: 8 x 7 bits -> 7 words of 0xFF, no bubbles
        add(1'b1, 3'd7, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        add(1'b1, 3'd7, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7);
        add(1'b1, 3'd7, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd14);
        add(1'b1, 3'd7, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd13);
        add(1'b1, 3'd7, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd12);
        add(1'b1, 3'd7, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd11);
        add(1'b1, 3'd7, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd10);
        add(1'b1, 3'd7, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9);
        add(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd8);
        add(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        // setup for reset in FLUSH: cnt = 10, FIFO full keeps it parked
        add(1'b1, 3'd7, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        add(1'b1, 3'd3, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7);
        add(1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd10);
        add(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10);

        for (int i = 0; i < vt.size(); i++) step(vt[i]);

        // asynchronous reset between edges while parked in FLUSH
        #2 reset = 1'b0;
        #1;
        check("mid_rst_q", q, 8'h00);
        check("mid_rst_wr", wr_req, 1'b0);
        check("mid_rst_occ", occupancy, 4'd0);
        check("mid_rst_ready", in_ready, 1'b1);
        check("mid_rst_fd", flush_done, 1'b0);
        #1 reset = 1'b1;
        mbits.delete();
        exp_q.delete();
        t = '{v: 1'b0, c: 3'd0, d: 8'h00, full: 1'b0, fl: 1'b0,
              e_rdy: 1'b1, e_wr: 1'b0, e_fd: 1'b0, e_occ: 4'd0};
        step(t);
        step(t);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
